// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU front end: ALU op codes,
// MIPS opcode/funct values, exception codes, operand selects and FSM states.
package alu_pkg;

    // ALU operation codes understood by the alu datapath
    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADDU = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SUBU = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_ADD  = 4'd11;
    localparam logic [3:0] ALU_SUB  = 4'd12;

    // MIPS primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // MIPS R-type funct values
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Exception cause codes
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Sign bit mask used to turn the unsigned compare into a signed one
    localparam logic [31:0] SIGN_BIT = 32'h8000_0000;

    // Operand A source
    typedef enum logic [1:0] {
        A_RS,
        A_RT,
        A_LUI
    } a_sel_e;

    // Operand B source
    typedef enum logic [2:0] {
        B_RT,
        B_SHAMT,
        B_RS5,
        B_SEXT,
        B_ZEXT,
        B_ZERO
    } b_sel_e;

    // Output-stage states
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_TRAP
    } state_e;

endpackage

// File: rtl/alu_dec.sv
// Combinational decoder: opcode/funct to ALU op, operand selects and the
// result-correction / exception qualifiers.
module alu_dec
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] op,
    output a_sel_e     a_sel,
    output b_sel_e     b_sel,
    output logic       is_signed_arith,
    output logic       is_slt,
    output logic       slt_flip,
    output logic       is_sra,
    output logic       ri
);

    // Decode one instruction; anything not listed is a reserved instruction
    always_comb begin
        op              = ALU_AND;
        a_sel           = A_RS;
        b_sel           = B_RT;
        is_signed_arith = 1'b0;
        is_slt          = 1'b0;
        slt_flip        = 1'b0;
        is_sra          = 1'b0;
        ri              = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin op = ALU_ADD; is_signed_arith = 1'b1; end
                    FN_ADDU: op = ALU_ADDU;
                    FN_SUB:  begin op = ALU_SUB; is_signed_arith = 1'b1; end
                    FN_SUBU: op = ALU_SUBU;
                    FN_AND:  op = ALU_AND;
                    FN_OR:   op = ALU_OR;
                    FN_XOR:  op = ALU_XOR;
                    FN_NOR:  op = ALU_NOR;
                    FN_SLT:  begin op = ALU_SLTU; is_slt = 1'b1; slt_flip = 1'b1; end
                    FN_SLTU: begin op = ALU_SLTU; is_slt = 1'b1; end
                    FN_SLL:  begin op = ALU_SLL; a_sel = A_RT; b_sel = B_SHAMT; end
                    FN_SRL:  begin op = ALU_SRL; a_sel = A_RT; b_sel = B_SHAMT; end
                    FN_SRA:  begin op = ALU_SRA; a_sel = A_RT; b_sel = B_SHAMT; is_sra = 1'b1; end
                    FN_SLLV: begin op = ALU_SLL; a_sel = A_RT; b_sel = B_RS5; end
                    FN_SRLV: begin op = ALU_SRL; a_sel = A_RT; b_sel = B_RS5; end
                    FN_SRAV: begin op = ALU_SRA; a_sel = A_RT; b_sel = B_RS5; is_sra = 1'b1; end
                    default: ri = 1'b1;
                endcase
            end
            OP_ADDI:  begin op = ALU_ADD; b_sel = B_SEXT; is_signed_arith = 1'b1; end
            OP_ADDIU: begin op = ALU_ADDU; b_sel = B_SEXT; end
            OP_SLTI:  begin op = ALU_SLTU; b_sel = B_SEXT; is_slt = 1'b1; slt_flip = 1'b1; end
            OP_SLTIU: begin op = ALU_SLTU; b_sel = B_SEXT; is_slt = 1'b1; end
            OP_ANDI:  begin op = ALU_AND; b_sel = B_ZEXT; end
            OP_ORI:   begin op = ALU_OR; b_sel = B_ZEXT; end
            OP_XORI:  begin op = ALU_XOR; b_sel = B_ZEXT; end
            OP_LUI:   begin op = ALU_OR; a_sel = A_LUI; b_sel = B_ZERO; end
            default:  ri = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage front end: steers operands into the external alu, corrects
// its result (slt normalisation, arithmetic right shift), and registers the
// outcome into a one-entry EX/MEM slot that can also hold a precise trap.
//
// Handshakes: a transfer happens on a rising edge where valid && ready; valid
// never waits on ready, and a presented output holds stable until taken.
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_opcode,
    input  logic [5:0]  in_funct,
    input  logic [4:0]  in_shamt,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    input  logic [15:0] in_imm,
    input  logic [4:0]  in_dst,
    input  logic [31:0] in_pc,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_y,
    input  logic        alu_zf,
    input  logic        alu_of,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_dst,
    output logic        out_wen,
    output logic        out_zf,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_pc
);

    logic [3:0]  dec_op;
    a_sel_e      a_sel;
    b_sel_e      b_sel;
    logic        is_signed_arith;
    logic        is_slt;
    logic        slt_flip;
    logic        is_sra;
    logic        ri;

    logic [31:0] a_pre;
    logic [31:0] b_pre;
    logic [31:0] fixed_y;
    logic        fault;
    logic [4:0]  fault_code;
    logic        accept;

    // Output-stage state, visible to checkers bound onto this module
    state_e      state;

    alu_dec u_dec (
        .opcode          (in_opcode),
        .funct           (in_funct),
        .op              (dec_op),
        .a_sel           (a_sel),
        .b_sel           (b_sel),
        .is_signed_arith (is_signed_arith),
        .is_slt          (is_slt),
        .slt_flip        (slt_flip),
        .is_sra          (is_sra),
        .ri              (ri)
    );

    // Operand A steering: rs for arithmetic, rt for shifts, shifted imm for lui
    always_comb begin
        a_pre = in_rs_val;
        case (a_sel)
            A_RS:    a_pre = in_rs_val;
            A_RT:    a_pre = in_rt_val;
            A_LUI:   a_pre = {in_imm, 16'h0000};
            default: a_pre = in_rs_val;
        endcase
    end

    // Operand B steering: register, shift amount, or extended immediate
    always_comb begin
        b_pre = in_rt_val;
        case (b_sel)
            B_RT:    b_pre = in_rt_val;
            B_SHAMT: b_pre = {27'd0, in_shamt};
            B_RS5:   b_pre = {27'd0, in_rs_val[4:0]};
            B_SEXT:  b_pre = {{16{in_imm[15]}}, in_imm};
            B_ZEXT:  b_pre = {16'h0000, in_imm};
            B_ZERO:  b_pre = 32'd0;
            default: b_pre = in_rt_val;
        endcase
    end

    // Flipping both sign bits makes the alu's unsigned compare order signed values
    assign alu_op = dec_op;
    assign alu_a  = slt_flip ? (a_pre ^ SIGN_BIT) : a_pre;
    assign alu_b  = slt_flip ? (b_pre ^ SIGN_BIT) : b_pre;

    // Result correction: slt yields all-ones for true, and the alu only shifts logically
    always_comb begin
        fixed_y = alu_y;
        if (is_slt) begin
            fixed_y = {31'd0, |alu_y};
        end else if (is_sra && alu_a[31]) begin
            fixed_y = alu_y | ~(32'hFFFF_FFFF >> alu_b);
        end
    end

    assign fault      = ri || (is_signed_arith && alu_of);
    assign fault_code = ri ? EXC_RI : EXC_OV;

    assign in_ready = !rst && !flush &&
                      ((state == ST_EMPTY) || ((state == ST_FULL) && out_ready));
    assign accept   = in_valid && in_ready;

    // Output-slot FSM with registered result and exception report
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_EMPTY;
            out_valid  <= 1'b0;
            out_wen    <= 1'b0;
            out_result <= 32'd0;
            out_dst    <= 5'd0;
            out_zf     <= 1'b0;
            exc_valid  <= 1'b0;
            exc_code   <= EXC_NONE;
            exc_pc     <= 32'd0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            out_wen   <= 1'b0;
            exc_valid <= 1'b0;
            exc_code  <= EXC_NONE;
        end else begin
            case (state)
                ST_EMPTY, ST_FULL: begin
                    if (accept) begin
                        out_valid  <= 1'b1;
                        out_result <= fixed_y;
                        out_dst    <= in_dst;
                        out_zf     <= alu_zf;
                        if (fault) begin
                            state     <= ST_TRAP;
                            out_wen   <= 1'b0;
                            exc_valid <= 1'b1;
                            exc_code  <= fault_code;
                            exc_pc    <= in_pc;
                        end else begin
                            state     <= ST_FULL;
                            out_wen   <= 1'b1;
                            exc_valid <= 1'b0;
                            exc_code  <= EXC_NONE;
                        end
                    end else if ((state == ST_FULL) && out_ready) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                        out_wen   <= 1'b0;
                    end
                end
                ST_TRAP: state <= ST_TRAP;
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with a behavioural alu attached.
module tb_alu_issue;

    localparam logic [5:0] RT    = 6'h00;
    localparam logic [5:0] ADDI  = 6'h08;
    localparam logic [5:0] ADDIU = 6'h09;
    localparam logic [5:0] SLTI  = 6'h0A;
    localparam logic [5:0] SLTIU = 6'h0B;
    localparam logic [5:0] ANDI  = 6'h0C;
    localparam logic [5:0] ORI   = 6'h0D;
    localparam logic [5:0] XORI  = 6'h0E;
    localparam logic [5:0] LUI   = 6'h0F;

    logic        clk, rst, flush;
    logic        in_valid, in_ready;
    logic [5:0]  in_opcode, in_funct;
    logic [4:0]  in_shamt;
    logic [31:0] in_rs_val, in_rt_val;
    logic [15:0] in_imm;
    logic [4:0]  in_dst;
    logic [31:0] in_pc;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_y;
    logic        alu_zf, alu_of;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dst;
    logic        out_wen, out_zf;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;

    int vectors = 0;
    int miscompares = 0;
    logic [38:0] exp_q[$];
    logic        rand_done;

    alu_issue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct(in_funct), .in_shamt(in_shamt),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
        .in_dst(in_dst), .in_pc(in_pc),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .alu_zf(alu_zf), .alu_of(alu_of),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dst(out_dst), .out_wen(out_wen), .out_zf(out_zf),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural alu: slt gives all-ones, op 10 shifts logically
    always_comb begin
        alu_y  = 32'd0;
        alu_of = 1'b0;
        case (alu_op)
            4'd0:  alu_y = alu_a & alu_b;
            4'd1:  alu_y = alu_a | alu_b;
            4'd2:  alu_y = alu_a + alu_b;
            4'd3:  alu_y = alu_a ^ alu_b;
            4'd4:  alu_y = ~(alu_a | alu_b);
            4'd6:  alu_y = alu_a - alu_b;
            4'd7:  alu_y = (alu_a < alu_b) ? 32'hFFFF_FFFF : 32'd0;
            4'd8:  alu_y = alu_a << alu_b[4:0];
            4'd9:  alu_y = alu_a >> alu_b[4:0];
            4'd10: alu_y = alu_a >> alu_b[4:0];
            4'd11: begin
                alu_y  = alu_a + alu_b;
                alu_of = (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]);
            end
            4'd12: begin
                alu_y  = alu_a - alu_b;
                alu_of = (alu_a[31] != alu_b[31]) && (alu_y[31] != alu_a[31]);
            end
            default: alu_y = 32'd0;
        endcase
        alu_zf = (alu_y == 32'd0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // MIPS reference semantics
    function automatic void ref_exec(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [4:0] sh, input logic [31:0] rs,
                                     input logic [31:0] rt, input logic [15:0] imm,
                                     output logic [31:0] res, output logic ov,
                                     output logic ri);
        logic [31:0] se;
        se  = {{16{imm[15]}}, imm};
        res = 32'd0;
        ov  = 1'b0;
        ri  = 1'b0;
        case (op)
            RT: case (fn)
                6'h00: res = rt << sh;
                6'h02: res = rt >> sh;
                6'h03: res = $unsigned($signed(rt) >>> sh);
                6'h04: res = rt << rs[4:0];
                6'h06: res = rt >> rs[4:0];
                6'h07: res = $unsigned($signed(rt) >>> rs[4:0]);
                6'h20: begin res = rs + rt; ov = (rs[31] == rt[31]) && (res[31] != rs[31]); end
                6'h21: res = rs + rt;
                6'h22: begin res = rs - rt; ov = (rs[31] != rt[31]) && (res[31] != rs[31]); end
                6'h23: res = rs - rt;
                6'h24: res = rs & rt;
                6'h25: res = rs | rt;
                6'h26: res = rs ^ rt;
                6'h27: res = ~(rs | rt);
                6'h2A: res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
                6'h2B: res = (rs < rt) ? 32'd1 : 32'd0;
                default: ri = 1'b1;
            endcase
            ADDI:  begin res = rs + se; ov = (rs[31] == se[31]) && (res[31] != rs[31]); end
            ADDIU: res = rs + se;
            SLTI:  res = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0;
            SLTIU: res = (rs < se) ? 32'd1 : 32'd0;
            ANDI:  res = rs & {16'h0, imm};
            ORI:   res = rs | {16'h0, imm};
            XORI:  res = rs ^ {16'h0, imm};
            LUI:   res = {imm, 16'h0};
            default: ri = 1'b1;
        endcase
    endfunction

    // driver: present one instruction, push its expectation when accepted
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                         input logic [4:0] dst, input logic [31:0] pc);
        logic [31:0] res;
        logic ov, ri, got;
        in_valid = 1'b1;
        in_opcode = op; in_funct = fn; in_shamt = sh;
        in_rs_val = rs; in_rt_val = rt; in_imm = imm; in_dst = dst; in_pc = pc;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                ref_exec(op, fn, sh, rs, rt, imm, res, ov, ri);
                if (!(ov || ri)) exp_q.push_back({1'b1, (res == 32'd0), dst, res});
            end
        end
        check("accept", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // scoreboard monitor: compare deliveries, check stability while stalled
    initial begin
        logic [38:0] cur, hold_val;
        logic hold_vld;
        hold_vld = 1'b0;
        hold_val = '0;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && !exc_valid) begin
                cur = {out_wen, out_zf, out_dst, out_result};
                if (hold_vld) check("stable", 64'(cur), 64'(hold_val));
                if (out_ready) begin
                    if (exp_q.size() == 0) check("out_expected", 64'(exp_q.size()), 64'd1);
                    else check("result", 64'(cur), 64'(exp_q.pop_front()));
                    hold_vld = 1'b0;
                end else begin
                    hold_vld = 1'b1;
                    hold_val = cur;
                end
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    task automatic do_flush(input logic with_valid);
        flush = 1'b1;
        in_valid = with_valid;
        in_opcode = RT; in_funct = 6'h21; in_rs_val = 32'd7; in_rt_val = 32'd8;
        in_dst = 5'd30; in_pc = 32'h0000_0F00;
        @(negedge clk);
        check("in_ready_flush", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_exc_valid", 64'(exc_valid), 64'd0);
    endtask

    logic [11:0] tbl [21];

    initial begin
        logic stall_seen;
        tbl = '{ {RT,6'h21}, {RT,6'h23}, {RT,6'h24}, {RT,6'h25}, {RT,6'h26}, {RT,6'h27},
                 {RT,6'h2A}, {RT,6'h2B}, {RT,6'h00}, {RT,6'h02}, {RT,6'h03}, {RT,6'h04},
                 {RT,6'h06}, {RT,6'h07}, {ADDIU,6'h00}, {SLTI,6'h00}, {SLTIU,6'h00},
                 {ANDI,6'h00}, {ORI,6'h00}, {XORI,6'h00}, {LUI,6'h00} };
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_opcode = 6'h0; in_funct = 6'h0; in_shamt = 5'h0; in_rs_val = 32'h0;
        in_rt_val = 32'h0; in_imm = 16'h0; in_dst = 5'h0; in_pc = 32'h0;
        repeat (3) @(negedge clk);
        check("in_ready_rst", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", {out_wen, out_zf, out_dst, out_result}, 64'd0);
        check("rst_exc", {exc_valid, exc_code, exc_pc}, 64'd0);

        // addu wrap to zero, one-cycle latency
        issue(RT, 6'h21, 5'd0, 32'hFFFF_FFFF, 32'd1, 16'h0, 5'd3, 32'h100);
        check("latency_valid", 64'(out_valid), 64'd1);

        // add overflow trap
        issue(RT, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'd1, 16'h0, 5'd4, 32'h0000_0104);
        check("ov_exc_valid", 64'(exc_valid), 64'd1);
        check("ov_exc_code", 64'(exc_code), 64'd12);
        check("ov_exc_pc", exc_pc, 64'h104);
        check("ov_wen", 64'(out_wen), 64'd0);
        check("ov_out_valid", 64'(out_valid), 64'd1);
        repeat (3) begin
            @(negedge clk);
            check("trap_in_ready", 64'(in_ready), 64'd0);
            check("trap_hold", 64'(exc_valid), 64'd1);
        end
        @(posedge clk); #1;
        do_flush(1'b0);
        @(negedge clk);
        check("post_flush_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // compares, shifts, immediates
        issue(RT, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1, 16'h0, 5'd5, 32'h108);
        issue(RT, 6'h2B, 5'd0, 32'hFFFF_FFFF, 32'd1, 16'h0, 5'd6, 32'h10C);
        issue(SLTI, 6'h0, 5'd0, 32'hFFFF_FFFB, 32'd0, 16'hFFFD, 5'd7, 32'h110);
        issue(SLTIU, 6'h0, 5'd0, 32'd5, 32'd0, 16'hFFFF, 5'd8, 32'h114);
        issue(RT, 6'h03, 5'd4, 32'd0, 32'h8000_0000, 16'h0, 5'd9, 32'h118);
        issue(RT, 6'h02, 5'd4, 32'd0, 32'h8000_0000, 16'h0, 5'd10, 32'h11C);
        issue(RT, 6'h07, 5'd0, 32'd36, 32'h8000_0000, 16'h0, 5'd11, 32'h120);
        issue(RT, 6'h03, 5'd4, 32'd0, 32'h4000_0000, 16'h0, 5'd12, 32'h124);
        issue(RT, 6'h00, 5'd31, 32'd0, 32'h0000_0003, 16'h0, 5'd13, 32'h128);
        issue(ADDI, 6'h0, 5'd0, 32'd10, 32'd0, 16'hFFF6, 5'd14, 32'h12C);
        issue(ANDI, 6'h0, 5'd0, 32'hFFFF_FFFF, 32'd0, 16'hF0F0, 5'd15, 32'h130);
        issue(LUI, 6'h0, 5'd0, 32'hDEAD_BEEF, 32'd0, 16'h1234, 5'd16, 32'h134);
        issue(RT, 6'h22, 5'd0, 32'd5, 32'd9, 16'h0, 5'd17, 32'h138);

        // random mix with random backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [11:0] e;
                    e = tbl[$urandom_range(0, 20)];
                    issue(e[11:6], e[5:0], 5'($urandom_range(0, 31)), $urandom, $urandom,
                          16'($urandom), 5'($urandom_range(0, 31)), 32'h200 + 32'(i * 4));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        // back-to-back with a two-cycle stall on the second result
        stall_seen = 1'b0;
        fork
            begin
                issue(RT, 6'h21, 5'd0, 32'd1, 32'd2, 16'h0, 5'd21, 32'h300);
                issue(RT, 6'h21, 5'd0, 32'd3, 32'd4, 16'h0, 5'd22, 32'h304);
                issue(RT, 6'h21, 5'd0, 32'd5, 32'd6, 16'h0, 5'd23, 32'h308);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(posedge clk); #1;
                    if (out_valid && out_dst == 5'd22) begin
                        stall_seen = 1'b1;
                        out_ready = 1'b0;
                        @(posedge clk);
                        @(posedge clk); #1;
                        out_ready = 1'b1;
                        break;
                    end
                end
            end
        join
        check("stall_seen", 64'(stall_seen), 64'd1);

        // reserved instruction, then flush with a competing instruction
        issue(RT, 6'h3F, 5'd0, 32'd1, 32'd1, 16'h0, 5'd24, 32'h400);
        check("ri_exc_code", 64'(exc_code), 64'd10);
        check("ri_exc_pc", exc_pc, 64'h400);
        check("ri_wen", 64'(out_wen), 64'd0);
        do_flush(1'b1);
        issue(6'h23, 6'h00, 5'd0, 32'd1, 32'd1, 16'h0, 5'd25, 32'h404);
        check("ri_op_code", 64'(exc_code), 64'd10);
        do_flush(1'b0);
        do_flush(1'b1);

        // reset discards a held result
        out_ready = 1'b0;
        issue(RT, 6'h25, 5'd0, 32'h0F, 32'hF0, 16'h0, 5'd26, 32'h500);
        void'(exp_q.pop_back());
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_exc", 64'(exc_valid), 64'd0);

        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
